// File: rtl/pic24_icsp_engine_pkg.sv
// Shared constants and state encoding for the PIC24/dsPIC ICSP engine.
package pic24_icsp_pkg;

  // 4-bit ICSP command codes, shifted out LSB first
  localparam logic [3:0]  ICSP_SIX            = 4'b0000;
  localparam logic [3:0]  ICSP_REGOUT         = 4'b0001;

  // Entry keys: standard ICSP and enhanced ICSP
  localparam logic [31:0] ICSP_ENTER_CODE     = 32'h4D434851;
  localparam logic [31:0] ENH_ICSP_ENTER_CODE = 32'h4D434850;

  // Entry sequence states come first, then IDLE and the command states
  typedef enum logic [3:0] {
    S_OFF, S_P6, S_PULSE, S_P18, S_KEY, S_P19, S_MCLR, S_PRE,
    S_IDLE, S_CMD, S_INSTR, S_IDLE8, S_P5, S_RD, S_GAP
  } icsp_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic24_icsp_engine_if.sv
// Command / response handshake bundle between the flash sequencer and the ICSP engine.
interface pic24_icsp_engine_if #(
  parameter int INSTR_W = 24,
  parameter int DATA_W  = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [INSTR_W-1:0] cmd_instr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_instr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_instr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pic24_icsp_engine_shift.sv
// PGC generator and bit shifter: one bit = low half then high half, CLK_DIV clk each.
// PGD changes with the low half; the read sample is taken on the clk where PGC falls.
module icsp_shift_unit #(
  parameter int CLK_DIV = 4,
  parameter int SW      = 32,
  parameter int RXW     = 16,
  parameter int BW      = $clog2(SW + 1)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [BW-1:0]  len,
  input  logic           msb_first,
  input  logic           dir,
  input  logic [SW-1:0]  tx,
  input  logic           pgd_in,
  output logic           pgc,
  output logic           pgd_out,
  output logic [RXW-1:0] rx_word,
  output logic           done
);
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic           act;
  logic           dir_q;
  logic [DVW-1:0] div;
  logic [BW-1:0]  cnt;
  logic [BW-1:0]  len_q;
  logic [SW-1:0]  sr;
  logic [SW-1:0]  rx;
  logic [SW-1:0]  tx_rev;
  logic [SW-1:0]  tx_load;
  logic           tick;

  // MSB-first words are bit-reversed on load so one LSB-first shifter serves both orders
  always_comb begin
    for (int i = 0; i < SW; i++) tx_rev[i] = tx[SW-1-i];
    tx_load = msb_first ? (tx_rev >> (SW - int'(len))) : tx;
  end

  assign tick    = act & (div == DVW'(CLK_DIV - 1));
  // done is combinational so the sequencer can chain the next field with no dead bit
  assign done    = tick & pgc & (cnt == BW'(1));
  assign pgd_out = act & dir_q & sr[0];
  // received bits enter at the top; realign so bit 0 is the first bit read
  assign rx_word = RXW'(rx >> (SW - int'(len_q)));

  // divider, half-period phase (= PGC), bit counter and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act   <= 1'b0;
      pgc   <= 1'b0;
      div   <= '0;
      cnt   <= '0;
      len_q <= '0;
      dir_q <= 1'b0;
      sr    <= '0;
      rx    <= '0;
    end else if (start) begin
      act   <= 1'b1;
      pgc   <= 1'b0;
      div   <= '0;
      cnt   <= len;
      len_q <= len;
      dir_q <= dir;
      sr    <= tx_load;
    end else if (act) begin
      if (tick) begin
        div <= '0;
        pgc <= ~pgc;
        if (pgc) begin
          sr  <= {1'b0, sr[SW-1:1]};
          rx  <= {pgd_in, rx[SW-1:1]};
          cnt <= cnt - BW'(1);
          if (cnt == BW'(1)) act <= 1'b0;
        end
      end else begin
        div <= div + DVW'(1);
      end
    end
  end

endmodule

// File: rtl/pic24_icsp_engine.sv
// PIC24/dsPIC ICSP master: MCLR/key entry, then SIX and REGOUT commands from a
// valid/ready port, REGOUT data returned on a valid/ready response port.
module pic24_icsp_engine
  import pic24_icsp_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter logic [31:0] ENTRY_KEY  = ICSP_ENTER_CODE,
  parameter int          INSTR_W    = 24,
  parameter int          DATA_W     = 16,
  parameter int          T_P6       = 6,
  parameter int          T_P18      = 2,
  parameter int          T_P4       = 2,
  parameter int          T_P5       = 1,
  parameter int          T_P19      = 8000,
  parameter int          T_P7       = 200000,
  parameter bit          AUTO_ENTER = 1'b1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter,
  input  logic                 exit,
  pic24_icsp_engine_if.slave   bus,
  output logic                 in_icsp,
  output logic                 busy,
  output logic                 pgc,
  output logic                 pgd_out,
  output logic                 pgd_oe,
  input  logic                 pgd_in,
  output logic                 mclr_n
);
  localparam int SW = imax(32, imax(INSTR_W, DATA_W));
  localparam int BW = $clog2(SW + 1);
  localparam int DW = $clog2(imax(T_P7, T_P19) + 1);

  icsp_state_e        state, state_n;
  logic [DW-1:0]      dly, dly_ld;
  logic               dly_zero;
  logic               auto_pend;
  logic               op_q;
  logic [INSTR_W-1:0] instr_q;
  logic               pgd_s1, pgd_s2;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               cmd_rdy, cmd_acc, rsp_load;

  logic               sh_start, sh_msb, sh_dir;
  logic [BW-1:0]      sh_len;
  logic [SW-1:0]      sh_tx;
  logic               sh_pgc, sh_pgd, sh_done;
  logic [DATA_W-1:0]  sh_rx;

  icsp_shift_unit #(.CLK_DIV(CLK_DIV), .SW(SW), .RXW(DATA_W), .BW(BW)) u_shift (
    .clk(clk), .rst(rst), .start(sh_start), .len(sh_len), .msb_first(sh_msb),
    .dir(sh_dir), .tx(sh_tx), .pgd_in(pgd_s2), .pgc(sh_pgc), .pgd_out(sh_pgd),
    .rx_word(sh_rx), .done(sh_done)
  );

  assign dly_zero = (dly == '0);
  // exit and enter both beat a pending command in IDLE
  assign cmd_rdy  = (state == S_IDLE) & ~rsp_valid_q & ~exit & ~enter;
  assign cmd_acc  = bus.cmd_valid & cmd_rdy;
  assign rsp_load = (state == S_GAP) & dly_zero & op_q;

  // next state and shift-unit launch for each field of the protocol
  always_comb begin
    state_n  = state;
    sh_start = 1'b0;
    sh_len   = '0;
    sh_msb   = 1'b0;
    sh_dir   = 1'b1;
    sh_tx    = '0;
    case (state)
      S_OFF:   if (enter | auto_pend) state_n = S_P6;
      S_P6:    if (dly_zero) state_n = S_PULSE;
      S_PULSE: if (dly_zero) state_n = S_P18;
      S_P18:   if (dly_zero) begin
                 state_n  = S_KEY;
                 sh_start = 1'b1;
                 sh_len   = BW'(32);
                 sh_msb   = 1'b1;
                 sh_tx    = SW'(ENTRY_KEY);
               end
      S_KEY:   if (sh_done) state_n = S_P19;
      S_P19:   if (dly_zero) state_n = S_MCLR;
      S_MCLR:  if (dly_zero) begin
                 state_n  = S_PRE;
                 sh_start = 1'b1;
                 sh_len   = BW'(9);
               end
      S_PRE:   if (sh_done) state_n = S_IDLE;
      S_IDLE:  if (exit) state_n = S_OFF;
               else if (enter) state_n = S_P6;
               else if (cmd_acc) begin
                 state_n  = S_CMD;
                 sh_start = 1'b1;
                 sh_len   = BW'(4);
                 sh_tx    = SW'(bus.cmd_op ? ICSP_REGOUT : ICSP_SIX);
               end
      S_CMD:   if (sh_done) begin
                 sh_start = 1'b1;
                 if (op_q) begin
                   state_n = S_IDLE8;
                   sh_len  = BW'(8);
                 end else begin
                   state_n = S_INSTR;
                   sh_len  = BW'(INSTR_W);
                   sh_tx   = SW'(instr_q);
                 end
               end
      S_INSTR: if (sh_done) state_n = S_GAP;
      S_IDLE8: if (sh_done) state_n = S_P5;
      S_P5:    if (dly_zero) begin
                 state_n  = S_RD;
                 sh_start = 1'b1;
                 sh_len   = BW'(DATA_W);
                 sh_dir   = 1'b0;
               end
      S_RD:    if (sh_done) state_n = S_GAP;
      S_GAP:   if (dly_zero) state_n = S_IDLE;
      default: state_n = S_OFF;
    endcase
  end

  // delay reload value for the state being entered (counts down to zero)
  always_comb begin
    dly_ld = '0;
    case (state_n)
      S_P6:    dly_ld = DW'(T_P6 - 1);
      S_PULSE: dly_ld = DW'(1);
      S_P18:   dly_ld = DW'(T_P18 - 1);
      S_P19:   dly_ld = DW'(T_P19 - 1);
      S_MCLR:  dly_ld = DW'(T_P7 - 1);
      S_P5:    dly_ld = DW'(T_P5 - 1);
      S_GAP:   dly_ld = DW'(T_P4 - 1);
      default: dly_ld = '0;
    endcase
  end

  // state register, delay counter, latched command, one-shot auto entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_OFF;
      dly       <= '0;
      auto_pend <= AUTO_ENTER;
      op_q      <= 1'b0;
      instr_q   <= '0;
    end else begin
      state     <= state_n;
      auto_pend <= 1'b0;
      if (state_n != state) dly <= dly_ld;
      else if (!dly_zero)   dly <= dly - DW'(1);
      if (cmd_acc) begin
        op_q    <= bus.cmd_op;
        instr_q <= bus.cmd_instr;
      end
    end
  end

  // two-flop synchroniser on the PGD pad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pgd_s1 <= 1'b0;
      pgd_s2 <= 1'b0;
    end else begin
      pgd_s1 <= pgd_in;
      pgd_s2 <= pgd_s1;
    end
  end

  // REGOUT result is published only once the full read and gap have completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rsp_load) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= sh_rx;
    end else if (rsp_valid_q & bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign mclr_n  = !(state inside {S_OFF, S_P6, S_P18, S_KEY, S_P19});
  assign pgd_oe  = !(state inside {S_P5, S_RD});
  assign pgd_out = pgd_oe & sh_pgd;
  assign pgc     = sh_pgc;
  assign in_icsp = state inside {S_IDLE, S_CMD, S_INSTR, S_IDLE8, S_P5, S_RD, S_GAP};
  assign busy    = !(state inside {S_OFF, S_IDLE});

endmodule
